// File: rtl/core_pkg.sv
// Shared types for the core's memory arbiter: arbiter states, requester IDs and word width.
package core_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqIdIf = 1'b0,
    ReqIdD  = 1'b1
  } req_id_e;

  // Busy state entered after granting the given requester.
  function automatic arb_state_e busy_state(req_id_e id);
    return (id == ReqIdD) ? StBusyD : StBusyI;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; counts up to Max and holds there.
module sat_counter #(
  parameter int unsigned Max   = 4,
  parameter int unsigned Width = $clog2(Max + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Width'(Max))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage, with pipeline stalls.
// At most one grant per cycle; read data is returned (and acked) the cycle after the grant.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ack,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  output logic [3:0]        m_wmask,
  input  logic [WORD_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  arb_state_e state_q, state_d;
  logic       we_q, we_d;
  logic [CntW-1:0] starve_cnt;

  logic if_elig, d_elig, if_blocked, starved;
  logic if_grant, d_grant;

  // Acks come straight from the state; an acked request is not eligible, so it is never regranted.
  assign if_ack  = ~rst & (state_q == StBusyI) & ~if_cancel;
  assign d_ack   = ~rst & (state_q == StBusyD);

  assign if_elig    = if_req & ~if_ack;
  assign d_elig     = d_req & ~d_ack;
  assign if_blocked = if_cancel & (state_q != StBusyI);
  assign starved    = (starve_cnt == CntW'(STARVE_MAX));

  assign if_grant = ~rst & if_elig & ~if_blocked & (starved | ~d_elig);
  assign d_grant  = ~rst & d_elig & ~if_grant;

  sat_counter #(
    .Max (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~if_req | if_grant),
    .inc_i (if_elig & ~if_grant),
    .cnt_o (starve_cnt)
  );

  always_comb begin
    state_d = StIdle;
    we_d    = 1'b0;
    if (if_grant) begin
      state_d = busy_state(ReqIdIf);
    end else if (d_grant) begin
      state_d = busy_state(ReqIdD);
      we_d    = d_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    m_en    = if_grant | d_grant;
    m_we    = d_grant & d_we;
    m_addr  = '0;
    m_wdata = '0;
    m_wmask = '0;
    if (if_grant) begin
      m_addr = if_addr;
    end else if (d_grant) begin
      m_addr = d_addr;
      if (d_we) begin
        m_wdata = d_wdata;
        m_wmask = d_wmask;
      end
    end
  end

  // Store acks return zero data; a cancelled fetch slot returns nothing.
  assign if_rdata = if_ack ? m_rdata : '0;
  assign d_rdata  = (d_ack && !we_q) ? m_rdata : '0;

  assign stall_if  = ~rst & if_req & ~if_ack;
  assign stall_mem = ~rst & d_req & ~d_ack;

endmodule
